radix5_out_serializer: RTL and testbench

- Parallel-to-serial converter at the output of a radix-5 butterfly stage.
- Accepts one frame of 5 complex results (re/img, 32-bit each) in a single transfer.
- Streams the frame out one complex sample per cycle over a valid/ready handshake.
- Back-to-back frames are supported with no bubble cycle. Output order is fixed: index 0 first, index N-1 last.

---
 rtl/fft_pkg.sv | 18 +
 rtl/sample_mux_n.sv | 30 +++
 rtl/radix5_out_serializer.sv | 92 +++++++++
 tb/tb_radix5_out_serializer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: component width, radix-5 frame size,
// the complex sample type and an index-width helper.
package fft_pkg;

  localparam int DW       = 32;
  localparam int RADIX5_N = 5;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] img;
  } cplx_t;

  // Bits needed to index 0..n-1; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sample_mux_n.sv
// Combinational N:1 selector of one complex sample out of a packed frame,
// forced to zero when en is low.
module sample_mux_n
  import fft_pkg::*;
#(
  parameter int DW = fft_pkg::DW,
  parameter int N  = RADIX5_N,
  parameter int IW = idx_width(N)
) (
  input  logic [N*DW-1:0] re_bus,
  input  logic [N*DW-1:0] img_bus,
  input  logic [IW-1:0]   idx,
  input  logic            en,
  output logic [DW-1:0]   re,
  output logic [DW-1:0]   img
);

  always_comb begin
    // NOTE: default every output first so no path through the loop leaves a latch.
    re  = '0;
    img = '0;
    for (int k = 0; k < N; k++) begin
      if (en && idx == IW'(k)) begin
        re  = re_bus[k*DW +: DW];
        img = img_bus[k*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/radix5_out_serializer.sv
// Radix-5 butterfly output serializer: one N-sample frame in, one sample per
// cycle out. Optional RADIX5_OUT_SERIALIZER_FRAME_CNT_EN adds a frame counter.
module radix5_out_serializer
  import fft_pkg::*;
#(
  parameter int DW = fft_pkg::DW,
  parameter int N  = RADIX5_N,
  parameter int IW = idx_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_re,
  input  logic [N*DW-1:0] in_img,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_re,
  output logic [DW-1:0]   out_img,
  output logic [IW-1:0]   out_idx,
  output logic            out_last
`ifdef RADIX5_OUT_SERIALIZER_FRAME_CNT_EN
  ,
  output logic [15:0]     frame_cnt
`endif
);

  logic [N*DW-1:0] buf_re;
  logic [N*DW-1:0] buf_img;
  logic            full;
  logic [IW-1:0]   idx;
  logic            in_acc;
  logic            out_acc;

  assign out_valid = full;
  assign out_idx   = idx;
  assign out_last  = full && (idx == IW'(N - 1));
  // Accepting on the last sample lets the next frame follow with no bubble.
  assign in_ready  = !full || (out_ready && out_last);
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;

  // NOTE: the frame buffer has no reset; full=0 masks its contents.
  always_ff @(posedge clk) begin
    if (in_acc) begin
      buf_re  <= in_re;
      buf_img <= in_img;
    end
  end

  // NOTE: sequential state is written with <= only, so all edges see old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      idx  <= '0;
    end else if (in_acc) begin
      full <= 1'b1;
      idx  <= '0;
    end else if (out_acc) begin
      if (out_last) begin
        full <= 1'b0;
        idx  <= '0;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

`ifdef RADIX5_OUT_SERIALIZER_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (out_acc && out_last) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

  sample_mux_n #(
    .DW (DW),
    .N  (N),
    .IW (IW)
  ) u_mux (
    .re_bus  (buf_re),
    .img_bus (buf_img),
    .idx     (idx),
    .en      (full),
    .re      (out_re),
    .img     (out_img)
  );

endmodule

// File: tb/tb_radix5_out_serializer.sv
// Directed bench for radix5_out_serializer: reset, single frame, back-to-back
// frames, downstream stall, mid-frame reset and the optional frame counter.
module tb_radix5_out_serializer;
  import fft_pkg::*;

  localparam int TDW = 32;
  localparam int TN  = 5;
  localparam int TIW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [TN*TDW-1:0] in_re;
  logic [TN*TDW-1:0] in_img;
  logic             out_valid;
  logic             out_ready;
  logic [TDW-1:0]   out_re;
  logic [TDW-1:0]   out_img;
  logic [TIW-1:0]   out_idx;
  logic             out_last;
`ifdef RADIX5_OUT_SERIALIZER_FRAME_CNT_EN
  logic [15:0]      frame_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  radix5_out_serializer #(.DW(TDW), .N(TN), .IW(TIW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_img    (in_img),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_img   (out_img),
    .out_idx   (out_idx),
    .out_last  (out_last)
`ifdef RADIX5_OUT_SERIALIZER_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Real parts base..base+4, imaginary parts -1..-5.
  function automatic logic [TN*TDW-1:0] pack_re(input int base);
    logic [TN*TDW-1:0] r;
    for (int k = 0; k < TN; k++) r[k*TDW +: TDW] = TDW'(base + k);
    return r;
  endfunction

  function automatic logic [TN*TDW-1:0] pack_img();
    logic [TN*TDW-1:0] r;
    for (int k = 0; k < TN; k++) r[k*TDW +: TDW] = TDW'(-(k + 1));
    return r;
  endfunction

  // Advance one edge, leave room to change inputs before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sample(input string tag, input int base, input int k);
    cplx_t e;
    e.re  = TDW'(base + k);
    e.img = TDW'(-(k + 1));
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"},  {out_re, out_img}, e);
    check({tag, "_idx"},   64'(out_idx), 64'(k));
    check({tag, "_last"},  64'(out_last), 64'(k == TN - 1));
  endtask

  task automatic send_frame(input string tag, input int base);
    in_valid = 1'b1;
    in_re    = pack_re(base);
    in_img   = pack_img();
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    #1;
  endtask

  task automatic stream_frame(input string tag, input int base);
    for (int k = 0; k < TN; k++) begin
      expect_sample(tag, base, k);
      step();
      #1;
    end
    check({tag, "_done"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_re     = '0;
    in_img    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_data",  {out_re, out_img}, 64'd0);
    check("rst_idx",   64'(out_idx), 64'd0);
    check("rst_last",  64'(out_last), 64'd0);

    // Single frame at full rate.
    send_frame("single", 1);
    stream_frame("single", 1);

    // Two frames with in_valid held high; second accepted on A's last sample.
    in_valid = 1'b1;
    in_re    = pack_re(10);
    in_img   = pack_img();
    #1;
    check("b2b_in_ready", 64'(in_ready), 64'd1);
    step();
    in_re = pack_re(20);
    #1;
    for (int c = 0; c < 2 * TN; c++) begin
      expect_sample("b2b", (c < TN) ? 10 : 20, c % TN);
      check("b2b_ready", 64'(in_ready), 64'((c % TN) == TN - 1));
      step();
      if (c == TN - 1) in_valid = 1'b0;
      #1;
    end
    check("b2b_done", 64'(out_valid), 64'd0);

    // Downstream stall on idx 2; a competing frame must be ignored.
    send_frame("stall", 30);
    for (int k = 0; k < 2; k++) begin
      expect_sample("stall_pre", 30, k);
      step();
      #1;
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_re     = pack_re(90);
    #1;
    for (int s = 0; s < 3; s++) begin
      expect_sample("stall_hold", 30, 2);
      check("stall_ready", 64'(in_ready), 64'd0);
      step();
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int k = 2; k < TN; k++) begin
      expect_sample("stall_post", 30, k);
      step();
      #1;
    end
    check("stall_done", 64'(out_valid), 64'd0);

    // Reset after idx 1 drops the rest of the frame.
    send_frame("midrst", 40);
    expect_sample("midrst_pre", 40, 0);
    step();
    #1;
    expect_sample("midrst_pre", 40, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_idx",   64'(out_idx), 64'd0);
    check("midrst_data",  {out_re, out_img}, 64'd0);
    check("midrst_ready", 64'(in_ready), 64'd1);
    send_frame("after_rst", 7);
    stream_frame("after_rst", 7);

`ifdef RADIX5_OUT_SERIALIZER_FRAME_CNT_EN
    // One frame completed since the mid-frame reset; two more make three.
    send_frame("cnt_a", 50);
    stream_frame("cnt_a", 50);
    send_frame("cnt_b", 60);
    stream_frame("cnt_b", 60);
    check("frame_cnt", 64'(frame_cnt), 64'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
